// File: rtl/axi_addr_remapper.sv
// AXI4 address remapper: windowed base/mask decode on AW/AR, rewrite of the
// masked upper address bits to a per-region target, and an internal DECERR
// responder for misses. Misses wait for all downstream traffic in their
// direction to retire so that per-ID response ordering is preserved.
module axi_addr_remapper #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int ID_W      = 4,
    parameter int N_REGION  = 2,
    parameter logic [N_REGION*ADDR_W-1:0] REGION_BASE   = {N_REGION{32'h0000_0000}},
    parameter logic [N_REGION*ADDR_W-1:0] REGION_MASK   = {N_REGION{32'hF000_0000}},
    parameter logic [N_REGION*ADDR_W-1:0] REGION_TARGET = {N_REGION{32'h8000_0000}},
    parameter int MAX_OUTST = 8
) (
    input  logic                aclk,
    input  logic                aresetn,
    // slave AW / W / B
    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awlock,
    input  logic [3:0]          s_axi_awcache,
    input  logic [2:0]          s_axi_awprot,
    input  logic [3:0]          s_axi_awqos,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_W-1:0]     s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    // slave AR / R
    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arlock,
    input  logic [3:0]          s_axi_arcache,
    input  logic [2:0]          s_axi_arprot,
    input  logic [3:0]          s_axi_arqos,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [ID_W-1:0]     s_axi_rid,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    // master AW / W / B
    output logic [ID_W-1:0]     m_axi_awid,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic                m_axi_awlock,
    output logic [3:0]          m_axi_awcache,
    output logic [2:0]          m_axi_awprot,
    output logic [3:0]          m_axi_awqos,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [ID_W-1:0]     m_axi_bid,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    // master AR / R
    output logic [ID_W-1:0]     m_axi_arid,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [7:0]          m_axi_arlen,
    output logic [2:0]          m_axi_arsize,
    output logic [1:0]          m_axi_arburst,
    output logic                m_axi_arlock,
    output logic [3:0]          m_axi_arcache,
    output logic [2:0]          m_axi_arprot,
    output logic [3:0]          m_axi_arqos,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [ID_W-1:0]     m_axi_rid,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rlast,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTST);

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
    } ax_t;

    typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_DRAIN, RD_ERR} rd_st_t;
    typedef enum logic [2:0] {WR_IDLE, WR_ISSUE, WR_DATA, WR_ABSORB, WR_DRAIN, WR_ERR} wr_st_t;

    rd_st_t          r_rd_state, w_rd_next;
    wr_st_t          r_wr_state, w_wr_next;
    ax_t             r_ar, r_aw;
    logic [7:0]      r_rd_beat;
    logic [CW-1:0]   r_rd_cnt, r_wr_cnt;
    logic            r_live;
    logic [ADDR_W:0] w_ar_dec, w_aw_dec;
    logic            w_rd_inc, w_rd_dec, w_wr_inc, w_wr_dec;

    // Returns {hit, remapped addr}; iterating high-to-low lets region 0 win overlaps.
    function automatic logic [ADDR_W:0] f_decode(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0]   res;
        logic [ADDR_W-1:0] msk;
        res = {1'b0, a};
        for (int i = N_REGION - 1; i >= 0; i--) begin
            msk = REGION_MASK[i*ADDR_W +: ADDR_W];
            if ((a & msk) == (REGION_BASE[i*ADDR_W +: ADDR_W] & msk))
                res = {1'b1, (REGION_TARGET[i*ADDR_W +: ADDR_W] & msk) | (a & ~msk)};
        end
        return res;
    endfunction

    assign w_ar_dec = f_decode(s_axi_araddr);
    assign w_aw_dec = f_decode(s_axi_awaddr);

    // Holds the slave address channels closed during and right after reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_live <= 1'b0;
        else          r_live <= 1'b1;
    end

    // Capture AR/AW with the remapped address; count DECERR read beats.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ar      <= '0;
            r_aw      <= '0;
            r_rd_beat <= '0;
        end else begin
            if (s_axi_arvalid && s_axi_arready) begin
                r_ar      <= '{id: s_axi_arid, addr: w_ar_dec[ADDR_W-1:0], len: s_axi_arlen,
                               size: s_axi_arsize, burst: s_axi_arburst, lock: s_axi_arlock,
                               cache: s_axi_arcache, prot: s_axi_arprot, qos: s_axi_arqos};
                r_rd_beat <= '0;
            end else if (r_rd_state == RD_ERR && s_axi_rready) begin
                r_rd_beat <= r_rd_beat + 8'd1;
            end
            if (s_axi_awvalid && s_axi_awready)
                r_aw <= '{id: s_axi_awid, addr: w_aw_dec[ADDR_W-1:0], len: s_axi_awlen,
                          size: s_axi_awsize, burst: s_axi_awburst, lock: s_axi_awlock,
                          cache: s_axi_awcache, prot: s_axi_awprot, qos: s_axi_awqos};
        end
    end

    assign w_rd_inc = m_axi_arvalid && m_axi_arready;
    assign w_rd_dec = m_axi_rvalid && m_axi_rready && m_axi_rlast;
    assign w_wr_inc = m_axi_awvalid && m_axi_awready;
    assign w_wr_dec = m_axi_bvalid && m_axi_bready;

    // Downstream outstanding counters; simultaneous issue and retire cancel out.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_rd_inc && !w_rd_dec && r_rd_cnt != MAX_C)    r_rd_cnt <= r_rd_cnt + CW'(1);
            else if (w_rd_dec && !w_rd_inc && r_rd_cnt != '0) r_rd_cnt <= r_rd_cnt - CW'(1);
            if (w_wr_inc && !w_wr_dec && r_wr_cnt != MAX_C)    r_wr_cnt <= r_wr_cnt + CW'(1);
            else if (w_wr_dec && !w_wr_inc && r_wr_cnt != '0) r_wr_cnt <= r_wr_cnt - CW'(1);
        end
    end

    // State registers for both independent FSMs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_state <= RD_IDLE;
            r_wr_state <= WR_IDLE;
        end else begin
            r_rd_state <= w_rd_next;
            r_wr_state <= w_wr_next;
        end
    end

    // Read next-state.
    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            RD_IDLE:  if (s_axi_arvalid && s_axi_arready) w_rd_next = w_ar_dec[ADDR_W] ? RD_ISSUE : RD_DRAIN;
            RD_ISSUE: if (w_rd_inc) w_rd_next = RD_IDLE;
            RD_DRAIN: if (r_rd_cnt == '0) w_rd_next = RD_ERR;
            RD_ERR:   if (s_axi_rready && r_rd_beat == r_ar.len) w_rd_next = RD_IDLE;
            default:  w_rd_next = RD_IDLE;
        endcase
    end

    // Read outputs. The counter can only fall while ISSUE waits, so once
    // arvalid rises it cannot be withdrawn before the handshake.
    always_comb begin
        s_axi_arready = 1'b0;
        m_axi_arvalid = 1'b0;
        s_axi_rvalid  = m_axi_rvalid;
        s_axi_rid     = m_axi_rid;
        s_axi_rdata   = m_axi_rdata;
        s_axi_rresp   = m_axi_rresp;
        s_axi_rlast   = m_axi_rlast;
        m_axi_rready  = s_axi_rready;
        case (r_rd_state)
            RD_IDLE:  s_axi_arready = r_live;
            RD_ISSUE: m_axi_arvalid = (r_rd_cnt < MAX_C);
            RD_ERR: begin
                s_axi_rvalid = 1'b1;
                s_axi_rid    = r_ar.id;
                s_axi_rdata  = '0;
                s_axi_rresp  = 2'b11;
                s_axi_rlast  = (r_rd_beat == r_ar.len);
                m_axi_rready = 1'b0;
            end
            default: ;
        endcase
    end

    // Write next-state.
    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            WR_IDLE:   if (s_axi_awvalid && s_axi_awready) w_wr_next = w_aw_dec[ADDR_W] ? WR_ISSUE : WR_ABSORB;
            WR_ISSUE:  if (w_wr_inc) w_wr_next = WR_DATA;
            WR_DATA:   if (s_axi_wvalid && s_axi_wready && s_axi_wlast) w_wr_next = WR_IDLE;
            WR_ABSORB: if (s_axi_wvalid && s_axi_wlast) w_wr_next = WR_DRAIN;
            WR_DRAIN:  if (r_wr_cnt == '0) w_wr_next = WR_ERR;
            WR_ERR:    if (s_axi_bready) w_wr_next = WR_IDLE;
            default:   w_wr_next = WR_IDLE;
        endcase
    end

    // Write outputs; W is only opened to the master after its AW has gone.
    always_comb begin
        s_axi_awready = 1'b0;
        m_axi_awvalid = 1'b0;
        s_axi_wready  = 1'b0;
        m_axi_wvalid  = 1'b0;
        s_axi_bvalid  = m_axi_bvalid;
        s_axi_bid     = m_axi_bid;
        s_axi_bresp   = m_axi_bresp;
        m_axi_bready  = s_axi_bready;
        case (r_wr_state)
            WR_IDLE:   s_axi_awready = r_live;
            WR_ISSUE:  m_axi_awvalid = (r_wr_cnt < MAX_C);
            WR_DATA: begin
                m_axi_wvalid = s_axi_wvalid;
                s_axi_wready = m_axi_wready;
            end
            WR_ABSORB: s_axi_wready = 1'b1;
            WR_ERR: begin
                s_axi_bvalid = 1'b1;
                s_axi_bid    = r_aw.id;
                s_axi_bresp  = 2'b11;
                m_axi_bready = 1'b0;
            end
            default: ;
        endcase
    end

    assign {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
            m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos} = r_ar;
    assign {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
            m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos} = r_aw;
    assign m_axi_wdata = s_axi_wdata;
    assign m_axi_wstrb = s_axi_wstrb;
    assign m_axi_wlast = s_axi_wlast;

endmodule
